// File: rtl/pico_pkg.sv
// Shared opcode/ALU encodings, controller state type and control-signal bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pico_pkg;

    localparam int PKG_OPCODE_W = 6;
    localparam int PKG_ALU_W    = 3;

    // Instruction opcodes understood by the controller
    localparam logic [PKG_OPCODE_W-1:0] OP_ADD  = 6'h00;
    localparam logic [PKG_OPCODE_W-1:0] OP_SUB  = 6'h01;
    localparam logic [PKG_OPCODE_W-1:0] OP_ADDI = 6'h02;
    localparam logic [PKG_OPCODE_W-1:0] OP_SUBI = 6'h03;
    localparam logic [PKG_OPCODE_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [PKG_OPCODE_W-1:0] OP_BNQ  = 6'h05;
    localparam logic [PKG_OPCODE_W-1:0] OP_JMP  = 6'h06;
    localparam logic [PKG_OPCODE_W-1:0] OP_MULT = 6'h07;
    localparam logic [PKG_OPCODE_W-1:0] OP_STIN = 6'h08;
    localparam logic [PKG_OPCODE_W-1:0] OP_LOUT = 6'h09;

    // ALU function codes; zero means "ALU not used" so both codes are non-zero
    localparam logic [PKG_ALU_W-1:0] RADD = 3'b001;
    localparam logic [PKG_ALU_W-1:0] RSUB = 3'b010;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_MULT_WAIT = 3'd2,
        ST_IN_WAIT   = 3'd3,
        ST_OUT_WAIT  = 3'd4,
        ST_HALT      = 3'd5
    } ctrl_state_t;

    typedef struct packed {
        logic [PKG_ALU_W-1:0] alu_func;
        logic                 reg_write;
        logic                 immediate;
        logic                 mult;
        logic                 pc_rel_branch;
        logic                 read_in;
        logic                 write_out;
        logic                 pc_en;
    } ctrl_sig_t;

    // All control outputs inactive
    function automatic ctrl_sig_t ctrl_idle();
        ctrl_sig_t s;
        s = '0;
        return s;
    endfunction

endpackage

// File: rtl/pico_mult_timer.sv
// Loadable down-counter that times the remaining cycles of a multi-cycle MULT.
// Latency: load/decrement take effect on the next clock; o_last is combinational from the count.
// Backpressure: none; saturates at zero if decremented while empty.
module pico_mult_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    // Load on MULT decode, count down while the multiplier is running
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_last = (r_count == WIDTH'(1));

endmodule

// File: rtl/pico_ctrl_fsm.sv
// Multi-cycle pico control unit: decodes opcode, sequences MULT/STIN/LOUT, gates PC via pc_en.
// Latency: single-cycle ops complete in DECODE; MULT takes MULT_CYCLES; STIN/LOUT wait on handshakes.
// Backpressure: pc_en held low while waiting on in_valid/out_ready; PICO_ILLEGAL_TRAP_EN enables illegal-op trap.
module pico_ctrl_fsm
    import pico_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALU_FUNC_W  = 3,
    parameter int MULT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  ZF,
    input  logic                  in_valid,
    input  logic                  out_ready,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic                  reg_write,
    output logic                  immediate,
    output logic                  mult,
    output logic                  pc_rel_branch,
    output logic                  read_in,
    output logic                  write_out,
    output logic                  pc_en,
    output logic                  illegal_op
);

    localparam int                CNT_W     = $clog2(MULT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam bit                MULT_ONE  = (MULT_CYCLES == 1);

    ctrl_state_t             r_state;
    ctrl_sig_t               w_sig;
    logic [PKG_OPCODE_W-1:0] w_op;
    logic                    w_load;
    logic                    w_dec;
    logic                    w_last;

    assign w_op = PKG_OPCODE_W'(opcode);

    // Control outputs for an instruction seen in DECODE
    function automatic ctrl_sig_t decode(input logic [PKG_OPCODE_W-1:0] op,
                                         input logic zf,
                                         input logic iv,
                                         input logic ordy);
        ctrl_sig_t s;
        s = ctrl_idle();
        case (op)
            OP_ADD:  begin s.alu_func = RADD; s.reg_write = 1'b1; s.pc_en = 1'b1; end
            OP_SUB:  begin s.alu_func = RSUB; s.reg_write = 1'b1; s.pc_en = 1'b1; end
            OP_ADDI: begin s.alu_func = RADD; s.reg_write = 1'b1; s.immediate = 1'b1; s.pc_en = 1'b1; end
            OP_SUBI: begin s.alu_func = RSUB; s.reg_write = 1'b1; s.immediate = 1'b1; s.pc_en = 1'b1; end
            OP_BEQ:  begin s.pc_rel_branch = zf;   s.pc_en = 1'b1; end
            OP_BNQ:  begin s.pc_rel_branch = !zf;  s.pc_en = 1'b1; end
            OP_JMP:  begin s.pc_rel_branch = 1'b1; s.pc_en = 1'b1; end
            OP_MULT: begin
                s.mult = 1'b1;
                // A one-cycle multiplier writes back in the decode cycle itself
                s.reg_write = MULT_ONE;
                s.pc_en     = MULT_ONE;
            end
            OP_STIN: begin s.read_in = 1'b1; s.reg_write = iv; s.pc_en = iv; end
            OP_LOUT: begin s.write_out = 1'b1; s.pc_en = ordy; end
            default: begin
`ifdef PICO_ILLEGAL_TRAP_EN
                s = ctrl_idle();
`else
                s.pc_en = 1'b1;
`endif
            end
        endcase
        return s;
    endfunction

    assign w_load = (r_state == ST_DECODE) && (w_op == OP_MULT) && !MULT_ONE;
    assign w_dec  = (r_state == ST_MULT_WAIT);

    pico_mult_timer #(
        .WIDTH(CNT_W)
    ) u_mult_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_load     (w_load),
        .i_load_val (MULT_LOAD),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    // Output decode from current state and live handshake inputs
    always_comb begin
        w_sig = ctrl_idle();
        case (r_state)
            ST_DECODE: w_sig = decode(w_op, ZF, in_valid, out_ready);
            ST_MULT_WAIT: begin
                w_sig.mult      = 1'b1;
                w_sig.reg_write = w_last;
                w_sig.pc_en     = w_last;
            end
            ST_IN_WAIT: begin
                w_sig.read_in   = 1'b1;
                w_sig.reg_write = in_valid;
                w_sig.pc_en     = in_valid;
            end
            ST_OUT_WAIT: begin
                w_sig.write_out = 1'b1;
                w_sig.pc_en     = out_ready;
            end
            default: w_sig = ctrl_idle();
        endcase
    end

    assign alu_func      = ALU_FUNC_W'(w_sig.alu_func);
    assign reg_write     = w_sig.reg_write;
    assign immediate     = w_sig.immediate;
    assign mult          = w_sig.mult;
    assign pc_rel_branch = w_sig.pc_rel_branch;
    assign read_in       = w_sig.read_in;
    assign write_out     = w_sig.write_out;
    assign pc_en         = w_sig.pc_en;

`ifdef PICO_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign illegal_op = r_illegal;
`else
    assign illegal_op = 1'b0;
`endif

    // Sequencer: enters wait states only when the op cannot finish in DECODE
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= ST_START;
`ifdef PICO_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_START: r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (w_op)
                        OP_MULT: r_state <= MULT_ONE ? ST_DECODE : ST_MULT_WAIT;
                        OP_STIN: r_state <= in_valid  ? ST_DECODE : ST_IN_WAIT;
                        OP_LOUT: r_state <= out_ready ? ST_DECODE : ST_OUT_WAIT;
                        OP_ADD, OP_SUB, OP_ADDI, OP_SUBI,
                        OP_BEQ, OP_BNQ, OP_JMP: r_state <= ST_DECODE;
                        default: begin
`ifdef PICO_ILLEGAL_TRAP_EN
                            r_state   <= ST_HALT;
                            r_illegal <= 1'b1;
`else
                            r_state   <= ST_DECODE;
`endif
                        end
                    endcase
                end
                ST_MULT_WAIT: if (w_last)    r_state <= ST_DECODE;
                ST_IN_WAIT:   if (in_valid)  r_state <= ST_DECODE;
                ST_OUT_WAIT:  if (out_ready) r_state <= ST_DECODE;
                ST_HALT:      r_state <= ST_HALT;
                default:      r_state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_ctrl_fsm.sv
// Scoreboard bench for pico_ctrl_fsm: instruction-level model expands each op into per-cycle expectations.
// Latency: expectations are pushed as each cycle is driven and popped by the monitor on the falling edge.
// Backpressure: STIN/LOUT handshakes are held off for a chosen number of cycles per instruction.
module tb_pico_ctrl_fsm;
    import pico_pkg::*;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [5:0] opcode;
    logic       ZF, in_valid, out_ready;
    logic [2:0] alu_func;
    logic       reg_write, immediate, mult, pc_rel_branch, read_in, write_out, pc_en, illegal_op;
    logic [10:0] act_vec;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pico_ctrl_fsm #(
        .OPCODE_W    (6),
        .ALU_FUNC_W  (3),
        .MULT_CYCLES (MC)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .opcode        (opcode),
        .ZF            (ZF),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .alu_func      (alu_func),
        .reg_write     (reg_write),
        .immediate     (immediate),
        .mult          (mult),
        .pc_rel_branch (pc_rel_branch),
        .read_in       (read_in),
        .write_out     (write_out),
        .pc_en         (pc_en),
        .illegal_op    (illegal_op)
    );

    assign act_vec = {alu_func, reg_write, immediate, mult, pc_rel_branch,
                      read_in, write_out, pc_en, illegal_op};

    function automatic logic [10:0] mk(input logic [2:0] a, input logic rw, input logic imm,
                                       input logic ml, input logic br, input logic rd,
                                       input logic wo, input logic pe, input logic il);
        return {a, rw, imm, ml, br, rd, wo, pe, il};
    endfunction

    // Drive one cycle of inputs and record what the outputs must be during it
    task automatic step(input logic rst_v, input logic [5:0] op, input logic zf,
                        input logic iv, input logic ordy, input logic [10:0] e, input string tag);
        @(posedge clk);
        #1;
        n_reset   = rst_v;
        opcode    = op;
        ZF        = zf;
        in_valid  = iv;
        out_ready = ordy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One instruction: length from its class, control outputs from its type, completion on last cycle
    task automatic run_instr(input logic [5:0] op, input int w, input logic zf, input string tag);
        int          len;
        logic        ivb, orb, done;
        logic [10:0] e;
        if (op == OP_MULT)                         len = MC;
        else if (op == OP_STIN || op == OP_LOUT)   len = w + 1;
        else                                       len = 1;
        for (int c = 0; c < len; c++) begin
            done = (c == len - 1);
            ivb  = 1'($urandom_range(0, 1));
            orb  = 1'($urandom_range(0, 1));
            if (op == OP_STIN) ivb = done;
            if (op == OP_LOUT) orb = done;
            case (op)
                OP_ADD:  e = mk(RADD, 1, 0, 0, 0, 0, 0, 1, 0);
                OP_SUB:  e = mk(RSUB, 1, 0, 0, 0, 0, 0, 1, 0);
                OP_ADDI: e = mk(RADD, 1, 1, 0, 0, 0, 0, 1, 0);
                OP_SUBI: e = mk(RSUB, 1, 1, 0, 0, 0, 0, 1, 0);
                OP_BEQ:  e = mk(3'd0, 0, 0, 0, zf, 0, 0, 1, 0);
                OP_BNQ:  e = mk(3'd0, 0, 0, 0, !zf, 0, 0, 1, 0);
                OP_JMP:  e = mk(3'd0, 0, 0, 0, 1, 0, 0, 1, 0);
                OP_MULT: e = mk(3'd0, done, 0, 1, 0, 0, 0, done, 0);
                OP_STIN: e = mk(3'd0, done, 0, 0, 0, 1, 0, done, 0);
                OP_LOUT: e = mk(3'd0, 0, 0, 0, 0, 0, 1, done, 0);
                default: e = mk(3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
            endcase
            step(1'b1, op, zf, ivb, orb, e, tag);
        end
    endtask

    // Monitor: compare every cycle that has an expectation queued
    initial begin
        logic [10:0] e;
        string       t;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (act_vec !== e) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b want=%b (alu,rw,imm,mult,br,rd,wo,pc_en,ill)",
                             t, cyc, act_vec, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[$];
        logic [5:0] op;
        logic       z;
        logic [10:0] zero;
        zero = '0;
        ops = '{OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_BEQ, OP_BNQ, OP_JMP, OP_MULT, OP_STIN, OP_LOUT};
`ifndef PICO_ILLEGAL_TRAP_EN
        ops.push_back(6'h3F);
        ops.push_back(6'h2A);
`endif
        n_reset = 1'b0; opcode = OP_ADD; ZF = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Reset, then one START cycle of idle outputs before the first decode
        step(1'b0, OP_ADD, 0, 1, 1, zero, "reset");
        step(1'b0, OP_ADD, 1, 1, 1, zero, "reset");
        step(1'b1, OP_ADD, 0, 0, 0, zero, "start");
        run_instr(OP_ADD, 0, 0, "first_add");

        // Branch resolution against ZF
        run_instr(OP_BEQ, 0, 1'b1, "beq_z1");
        run_instr(OP_BEQ, 0, 1'b0, "beq_z0");
        run_instr(OP_BNQ, 0, 1'b0, "bnq_z0");
        run_instr(OP_BNQ, 0, 1'b1, "bnq_z1");
        run_instr(OP_JMP, 0, 1'b0, "jmp");

        // Multi-cycle and handshake-gated ops
        run_instr(OP_MULT, 0, 0, "mult");
        run_instr(OP_STIN, 3, 0, "stin_w3");
        run_instr(OP_STIN, 0, 0, "stin_w0");
        run_instr(OP_LOUT, 0, 0, "lout_w0");
        run_instr(OP_LOUT, 2, 0, "lout_w2");
        run_instr(OP_MULT, 0, 1, "mult_b2b");
        run_instr(OP_MULT, 0, 0, "mult_b2b");

        // Reset during the multiplier's second cycle abandons the write-back
        step(1'b1, OP_MULT, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0), "mult_dec");
        step(1'b1, OP_MULT, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0), "mult_wait1");
        step(1'b0, OP_MULT, 0, 0, 0, zero, "rst_mid");
        step(1'b0, OP_MULT, 0, 0, 0, zero, "rst_mid");
        step(1'b1, OP_ADD, 0, 0, 0, zero, "rst_start");
        run_instr(OP_ADD, 0, 0, "rst_add");

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, ops.size() - 1)];
            z  = 1'($urandom_range(0, 1));
            run_instr(op, int'($urandom_range(0, 3)), z, "rand");
        end

`ifdef PICO_ILLEGAL_TRAP_EN
        // Unlisted opcode traps; flag is sticky until reset
        step(1'b1, 6'h3F, 0, 1, 1, zero, "ill_dec");
        for (int i = 0; i < 3; i++)
            step(1'b1, 6'h3F, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_halt");
        step(1'b0, OP_ADD, 0, 0, 0, zero, "ill_rst");
        step(1'b1, OP_ADD, 0, 0, 0, zero, "ill_start");
        run_instr(OP_ADD, 0, 0, "ill_add");
`else
        run_instr(6'h3F, 0, 0, "nop_3f");
        run_instr(OP_SUB, 0, 0, "after_nop");
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
